joy_combo_lock: RTL

- Parametrised joystick/keypad combination lock. Successor to the fixed 4-step lock.
- Each step needs a keypad digit and a joystick quadrant, both matching the programmed code.
- Adds over the fixed lock: N-step depth, configurable digit and ADC widths, 2-axis quadrant decode with deadband, per-key fail detection, inactivity timeout, and fail-count lockout.
- Sits between the ADC joystick sampler and keypad decoder on one side, and the display/unlock logic on the other.

---
 rtl/joy_combo_lock.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/joy_combo_lock.sv
// Joystick/keypad combination lock: each step needs the programmed keypad digit
// while the joystick sits in the programmed quadrant. Adds timeout and fail lockout.
module joy_combo_lock #(
    parameter int                STEPS       = 4,
    parameter int                DIGIT_W     = 3,
    parameter int                ADC_W       = 12,
    parameter logic [ADC_W-1:0]  THRESH_HI   = 12'hA00,
    parameter logic [ADC_W-1:0]  THRESH_LO   = 12'h600,
    parameter int                TIMEOUT_CYC = 50_000_000,
    parameter int                MAX_FAILS   = 3,
    parameter int                LOCKOUT_CYC = 250_000_000
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [ADC_W-1:0]                   adc_x,
    input  logic [ADC_W-1:0]                   adc_y,
    input  logic [STEPS*DIGIT_W-1:0]           code_digits,
    input  logic [STEPS*2-1:0]                 code_quads,
    input  logic                               key_valid,
    input  logic [DIGIT_W-1:0]                 key_code,
    input  logic                               clear,
    output logic                               pass_flag,
    output logic                               fail_pulse,
    output logic                               locked_out,
    output logic [$clog2(STEPS+1)-1:0]         step_idx,
    output logic [1:0]                         quad_now,
    output logic                               quad_valid,
    output logic [$clog2(MAX_FAILS+1)-1:0]     fail_count
);

    localparam int SW = $clog2(STEPS + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int LW = $clog2(LOCKOUT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTRY   = 2'd1,
        ST_PASS    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      step_idx_q, step_idx_d;
    logic [FW-1:0]      fail_count_q, fail_count_d;
    logic               fail_pulse_q, fail_pulse_d;
    logic               pass_flag_q, pass_flag_d;
    logic               locked_out_q, locked_out_d;
    logic [1:0]         quad_now_q, quad_now_d;
    logic               quad_valid_q, quad_valid_d;
    logic [TW-1:0]      idle_cnt_q, idle_cnt_d;
    logic [LW-1:0]      lock_cnt_q, lock_cnt_d;

    logic               x_hi_s, x_lo_s, y_hi_s, y_lo_s;
    logic [DIGIT_W-1:0] exp_digit_s;
    logic [1:0]         exp_quad_s;
    logic               match_s;

    // Quadrant decode; the last quadrant is held while either axis sits in the deadband
    always_comb begin
        x_hi_s       = (adc_x > THRESH_HI);
        x_lo_s       = (adc_x < THRESH_LO);
        y_hi_s       = (adc_y > THRESH_HI);
        y_lo_s       = (adc_y < THRESH_LO);
        quad_valid_d = (x_hi_s | x_lo_s) & (y_hi_s | y_lo_s);
        quad_now_d   = quad_now_q;
        if (quad_valid_d) begin
            case ({x_hi_s, y_hi_s})
                2'b11:   quad_now_d = 2'd0;
                2'b01:   quad_now_d = 2'd1;
                2'b00:   quad_now_d = 2'd2;
                2'b10:   quad_now_d = 2'd3;
                default: quad_now_d = quad_now_q;
            endcase
        end else begin
            quad_now_d = quad_now_q;
        end
    end

    // Select the code slice for the current step; code inputs are used live
    always_comb begin
        exp_digit_s = '0;
        exp_quad_s  = '0;
        for (int k = 0; k < STEPS; k++) begin
            exp_digit_s = (step_idx_q == SW'(k)) ? code_digits[k*DIGIT_W +: DIGIT_W] : exp_digit_s;
            exp_quad_s  = (step_idx_q == SW'(k)) ? code_quads[k*2 +: 2] : exp_quad_s;
        end
        match_s = key_valid && (key_code == exp_digit_s) && quad_valid_q && (quad_now_q == exp_quad_s);
    end

    // Next-state and output logic; clear beats key, key beats timeout expiry
    always_comb begin
        state_d      = state_q;
        step_idx_d   = step_idx_q;
        fail_count_d = fail_count_q;
        fail_pulse_d = 1'b0;
        idle_cnt_d   = idle_cnt_q;
        lock_cnt_d   = lock_cnt_q;
        case (state_q)
            ST_IDLE, ST_ENTRY: begin
                if (clear) begin
                    state_d    = ST_IDLE;
                    step_idx_d = '0;
                    idle_cnt_d = '0;
                end else if (key_valid) begin
                    idle_cnt_d = '0;
                    if (match_s) begin
                        if (step_idx_q == SW'(STEPS - 1)) begin
                            state_d      = ST_PASS;
                            step_idx_d   = SW'(STEPS);
                            fail_count_d = '0;
                        end else begin
                            state_d    = ST_ENTRY;
                            step_idx_d = step_idx_q + SW'(1);
                        end
                    end else begin
                        fail_pulse_d = 1'b1;
                        step_idx_d   = '0;
                        if (fail_count_q >= FW'(MAX_FAILS - 1)) begin
                            fail_count_d = FW'(MAX_FAILS);
                            state_d      = ST_LOCKOUT;
                            lock_cnt_d   = '0;
                        end else begin
                            fail_count_d = fail_count_q + FW'(1);
                            state_d      = ST_IDLE;
                        end
                    end
                end else if (state_q == ST_ENTRY) begin
                    if (idle_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                        state_d    = ST_IDLE;
                        step_idx_d = '0;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + TW'(1);
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end
            ST_PASS: begin
                if (clear) begin
                    state_d    = ST_IDLE;
                    step_idx_d = '0;
                end else begin
                    state_d = ST_PASS;
                end
            end
            ST_LOCKOUT: begin
                if (lock_cnt_q == LW'(LOCKOUT_CYC - 1)) begin
                    state_d      = ST_IDLE;
                    fail_count_d = '0;
                    lock_cnt_d   = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + LW'(1);
                end
            end
            default: begin
                state_d      = ST_IDLE;
                step_idx_d   = '0;
                fail_count_d = '0;
                idle_cnt_d   = '0;
                lock_cnt_d   = '0;
            end
        endcase
        pass_flag_d  = (state_d == ST_PASS);
        locked_out_d = (state_d == ST_LOCKOUT);
    end

    // State, counter and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            step_idx_q   <= '0;
            fail_count_q <= '0;
            fail_pulse_q <= 1'b0;
            pass_flag_q  <= 1'b0;
            locked_out_q <= 1'b0;
            quad_now_q   <= 2'd0;
            quad_valid_q <= 1'b0;
            idle_cnt_q   <= '0;
            lock_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            step_idx_q   <= step_idx_d;
            fail_count_q <= fail_count_d;
            fail_pulse_q <= fail_pulse_d;
            pass_flag_q  <= pass_flag_d;
            locked_out_q <= locked_out_d;
            quad_now_q   <= quad_now_d;
            quad_valid_q <= quad_valid_d;
            idle_cnt_q   <= idle_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end

    assign pass_flag  = pass_flag_q;
    assign fail_pulse = fail_pulse_q;
    assign locked_out = locked_out_q;
    assign step_idx   = step_idx_q;
    assign quad_now   = quad_now_q;
    assign quad_valid = quad_valid_q;
    assign fail_count = fail_count_q;

endmodule
